alu_unit: RTL and testbench

- Sequential 8-bit ALU that sits directly upstream of the processor flags register.
- Takes operands and opcode from the decode/control unit when `start` is asserted.
- Executes single-cycle, multi-cycle shift/rotate and iterative multiply operations.
- Presents a registered result, zero/carry/overflow, and a one-cycle `load_flags` strobe that drives the flags register load input directly.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_unit_if.sv | 34 +++
 rtl/alu_addsub.sv | 33 +++
 rtl/alu_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: default sizes, opcode map and
// the sequencing state encoding.
package alu_pkg;

   localparam int ALU_WIDTH = 8;
   localparam int ALU_OPW   = 4;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_ROL = 4'd10;
   localparam logic [3:0] OP_MUL = 4'd11;
   localparam logic [3:0] OP_CMP = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_MUL   = 2'd2,
      ST_FIN   = 2'd3
   } alu_state_e;

endpackage

// File: rtl/alu_unit_if.sv
// Control-unit <-> ALU bundle: operation launch inputs and the registered
// result/flag outputs that feed the flags register.
interface alu_unit_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OPW   = ALU_OPW
);

   logic             start;
   logic [OPW-1:0]   op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero_out;
   logic             carry_out;
   logic             overflow_out;
   logic             load_flags;

   modport master (
      output start, op, a, b, carry_in,
      input  busy, done, result, result_hi, zero_out, carry_out, overflow_out, load_flags
   );

   modport slave (
      input  start, op, a, b, carry_in,
      output busy, done, result, result_hi, zero_out, carry_out, overflow_out, load_flags
   );

endinterface

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor with carry-in; carry_o is the borrow when
// subtracting, ovf_o is signed two's-complement overflow.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             ovf_o
);

   logic [WIDTH:0] ext_s;

   // Extended-width add or subtract; bit WIDTH is carry out or borrow.
   always_comb begin
      ext_s = {(WIDTH+1){1'b0}};
      ovf_o = 1'b0;
      if (sub_i) begin
         ext_s = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
         ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (ext_s[WIDTH-1] != a_i[WIDTH-1]);
      end else begin
         ext_s = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
         ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (ext_s[WIDTH-1] != a_i[WIDTH-1]);
      end
   end

   assign sum_o   = ext_s[WIDTH-1:0];
   assign carry_o = ext_s[WIDTH];

endmodule

// File: rtl/alu_unit.sv
// Sequential ALU feeding the flags register: single-cycle arithmetic/logic,
// bit-serial shift/rotate and shift-add multiply, all with registered outputs.
module alu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OPW   = ALU_OPW
) (
   input  logic       clk,
   input  logic       reset_n,
   alu_unit_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   alu_state_e       state_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] mplr_q;
   logic [WIDTH-1:0] acc_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             load_flags_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic             zero_q;
   logic             carry_q;
   logic             ovf_q;

   logic             as_sub_s;
   logic             as_cin_s;
   logic [WIDTH-1:0] as_sum_s;
   logic             as_carry_s;
   logic             as_ovf_s;
   logic [WIDTH-1:0] logic_res_s;
   logic [WIDTH-1:0] shift_val_s;
   logic             shift_out_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH-1:0] mul_acc_d;
   logic [WIDTH-1:0] mul_plr_d;

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a_i     (bus.a),
      .b_i     (bus.b),
      .cin_i   (as_cin_s),
      .sub_i   (as_sub_s),
      .sum_o   (as_sum_s),
      .carry_o (as_carry_s),
      .ovf_o   (as_ovf_s)
   );

   // Adder mode: CMP shares the subtract path; only ADC/SBC consume carry_in.
   always_comb begin
      as_sub_s = 1'b0;
      as_cin_s = 1'b0;
      if ((bus.op == OP_SUB) || (bus.op == OP_SBC) || (bus.op == OP_CMP)) begin
         as_sub_s = 1'b1;
      end else begin
         as_sub_s = 1'b0;
      end
      if ((bus.op == OP_ADC) || (bus.op == OP_SBC)) begin
         as_cin_s = bus.carry_in;
      end else begin
         as_cin_s = 1'b0;
      end
   end

   // Bitwise operations on the launch operands.
   always_comb begin
      logic_res_s = {WIDTH{1'b0}};
      case (bus.op)
         OP_AND:  logic_res_s = bus.a & bus.b;
         OP_OR:   logic_res_s = bus.a | bus.b;
         OP_XOR:  logic_res_s = bus.a ^ bus.b;
         OP_NOT:  logic_res_s = ~bus.a;
         default: logic_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One shift/rotate step of the working register and the bit leaving it.
   always_comb begin
      shift_val_s = work_q;
      shift_out_s = 1'b0;
      case (op_q)
         OP_SHL: begin
            shift_val_s = {work_q[WIDTH-2:0], 1'b0};
            shift_out_s = work_q[WIDTH-1];
         end
         OP_SHR: begin
            shift_val_s = {1'b0, work_q[WIDTH-1:1]};
            shift_out_s = work_q[0];
         end
         OP_ROL: begin
            shift_val_s = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            shift_out_s = work_q[WIDTH-1];
         end
         default: begin
            shift_val_s = work_q;
            shift_out_s = 1'b0;
         end
      endcase
   end

   // Shift-add step: product high half in acc_q, low half migrates into mplr_q.
   always_comb begin
      mul_sum_s = {1'b0, acc_q};
      if (mplr_q[0]) begin
         mul_sum_s = {1'b0, acc_q} + {1'b0, work_q};
      end else begin
         mul_sum_s = {1'b0, acc_q};
      end
      mul_acc_d = mul_sum_s[WIDTH:1];
      mul_plr_d = {mul_sum_s[0], mplr_q[WIDTH-1:1]};
   end

   // Sequencer with registered result, flags and handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         op_q         <= 4'd0;
         work_q       <= {WIDTH{1'b0}};
         mplr_q       <= {WIDTH{1'b0}};
         acc_q        <= {WIDTH{1'b0}};
         cnt_q        <= {CW{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_flags_q <= 1'b0;
         result_q     <= {WIDTH{1'b0}};
         result_hi_q  <= {WIDTH{1'b0}};
         zero_q       <= 1'b0;
         carry_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         load_flags_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_FIN: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (bus.start) begin
                  op_q <= bus.op;
                  case (bus.op)
                     OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                        result_q     <= as_sum_s;
                        result_hi_q  <= {WIDTH{1'b0}};
                        zero_q       <= (as_sum_s == {WIDTH{1'b0}});
                        carry_q      <= as_carry_s;
                        ovf_q        <= as_ovf_s;
                        done_q       <= 1'b1;
                        load_flags_q <= 1'b1;
                     end
                     OP_CMP: begin
                        zero_q       <= (as_sum_s == {WIDTH{1'b0}});
                        carry_q      <= as_carry_s;
                        ovf_q        <= as_ovf_s;
                        done_q       <= 1'b1;
                        load_flags_q <= 1'b1;
                     end
                     OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        result_q     <= logic_res_s;
                        result_hi_q  <= {WIDTH{1'b0}};
                        zero_q       <= (logic_res_s == {WIDTH{1'b0}});
                        carry_q      <= 1'b0;
                        ovf_q        <= 1'b0;
                        done_q       <= 1'b1;
                        load_flags_q <= 1'b1;
                     end
                     OP_SHL, OP_SHR, OP_ROL: begin
                        if (bus.b[2:0] == 3'd0) begin
                           result_q     <= bus.a;
                           result_hi_q  <= {WIDTH{1'b0}};
                           zero_q       <= (bus.a == {WIDTH{1'b0}});
                           carry_q      <= 1'b0;
                           ovf_q        <= 1'b0;
                           done_q       <= 1'b1;
                           load_flags_q <= 1'b1;
                        end else begin
                           state_q <= ST_SHIFT;
                           busy_q  <= 1'b1;
                           work_q  <= bus.a;
                           cnt_q   <= CW'(bus.b[2:0]);
                        end
                     end
                     OP_MUL: begin
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                        work_q  <= bus.a;
                        mplr_q  <= bus.b;
                        acc_q   <= {WIDTH{1'b0}};
                        cnt_q   <= CW'(WIDTH);
                     end
                     default: begin
                        // Reserved opcode: acknowledge without touching flags.
                        done_q <= 1'b1;
                     end
                  endcase
               end else begin
                  op_q <= op_q;
               end
            end
            ST_SHIFT: begin
               work_q <= shift_val_s;
               cnt_q  <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q      <= ST_FIN;
                  busy_q       <= 1'b0;
                  result_q     <= shift_val_s;
                  result_hi_q  <= {WIDTH{1'b0}};
                  zero_q       <= (shift_val_s == {WIDTH{1'b0}});
                  carry_q      <= shift_out_s;
                  ovf_q        <= 1'b0;
                  done_q       <= 1'b1;
                  load_flags_q <= 1'b1;
               end else begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_MUL: begin
               acc_q  <= mul_acc_d;
               mplr_q <= mul_plr_d;
               cnt_q  <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q      <= ST_FIN;
                  busy_q       <= 1'b0;
                  result_q     <= mul_plr_d;
                  result_hi_q  <= mul_acc_d;
                  zero_q       <= ({mul_acc_d, mul_plr_d} == {(2*WIDTH){1'b0}});
                  carry_q      <= (mul_acc_d != {WIDTH{1'b0}});
                  ovf_q        <= (mul_acc_d != {WIDTH{1'b0}});
                  done_q       <= 1'b1;
                  load_flags_q <= 1'b1;
               end else begin
                  state_q <= ST_MUL;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.load_flags   = load_flags_q;
   assign bus.result       = result_q;
   assign bus.result_hi    = result_hi_q;
   assign bus.zero_out     = zero_q;
   assign bus.carry_out    = carry_q;
   assign bus.overflow_out = ovf_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: a behavioural model predicts each operation
// when it is launched; the prediction is popped and compared at done.
module tb_alu_unit;

   typedef struct {
      logic [7:0] r;
      logic [7:0] hi;
      logic       z;
      logic       c;
      logic       v;
      logic       lf;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   alu_unit_if #(.WIDTH(8), .OPW(4)) bus ();

   alu_unit #(.WIDTH(8), .OPW(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   logic [7:0] m_r, m_hi;
   logic       m_z, m_c, m_v;

   wire [19:0] obs_w = {bus.result, bus.result_hi, bus.zero_out, bus.carry_out,
                        bus.overflow_out, bus.load_flags};

   task automatic model_reset();
      m_r = 8'h00; m_hi = 8'h00; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
      sb.delete();
   endtask

   task automatic push_expect(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic cin);
      exp_t e;
      int full, sres, p, k;
      logic [7:0] v8;
      logic co;
      e.lf = 1'b1;
      e.lat = 1;
      if (op <= 4'd3 || op == 4'd12) begin
         if (op <= 4'd1) begin
            full = int'(a) + int'(b) + ((op == 4'd1) ? int'(cin) : 0);
            sres = int'($signed(a)) + int'($signed(b)) + ((op == 4'd1) ? int'(cin) : 0);
            m_c = (full > 255);
         end else begin
            full = int'(a) - int'(b) - ((op == 4'd3) ? int'(cin) : 0);
            sres = int'($signed(a)) - int'($signed(b)) - ((op == 4'd3) ? int'(cin) : 0);
            m_c = (full < 0);
         end
         m_v = (sres > 127) || (sres < -128);
         m_z = (full[7:0] == 8'h00);
         if (op != 4'd12) begin
            m_r = full[7:0];
            m_hi = 8'h00;
         end
      end else if (op >= 4'd4 && op <= 4'd7) begin
         if (op == 4'd4) m_r = a & b;
         else if (op == 4'd5) m_r = a | b;
         else if (op == 4'd6) m_r = a ^ b;
         else m_r = ~a;
         m_hi = 8'h00; m_z = (m_r == 8'h00); m_c = 1'b0; m_v = 1'b0;
      end else if (op >= 4'd8 && op <= 4'd10) begin
         k = int'(b[2:0]);
         v8 = a;
         co = 1'b0;
         for (int i = 0; i < k; i++) begin
            if (op == 4'd8) begin co = v8[7]; v8 = {v8[6:0], 1'b0}; end
            else if (op == 4'd9) begin co = v8[0]; v8 = {1'b0, v8[7:1]}; end
            else begin co = v8[7]; v8 = {v8[6:0], v8[7]}; end
         end
         m_r = v8; m_hi = 8'h00; m_z = (v8 == 8'h00); m_c = co; m_v = 1'b0;
         e.lat = (k == 0) ? 1 : k + 1;
      end else if (op == 4'd11) begin
         p = int'(a) * int'(b);
         m_r = p[7:0]; m_hi = p[15:8]; m_z = (p == 0); m_c = (p > 255); m_v = (p > 255);
         e.lat = 9;
      end else begin
         e.lf = 1'b0;
      end
      e.r = m_r; e.hi = m_hi; e.z = m_z; e.c = m_c; e.v = m_v;
      sb.push_back(e);
   endtask

   // Launch at a falling edge; returns at the falling edge one cycle after acceptance.
   task automatic drive_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.carry_in = cin;
      push_expect(op, a, b, cin);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat, output int busy_n);
      lat = lat0;
      busy_n = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (bus.busy === 1'b1) busy_n++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0; bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00; bus.carry_in = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({obs_w, bus.busy, bus.done} !== 22'd0) $display("FAIL reset_state: got %h want 0", {obs_w, bus.busy, bus.done});
      else passed++;
      reset_n = 1'b1;
   endtask

   task automatic test_table(input string name, input logic [3:0] ops[], input logic [7:0] as[],
                             input logic [7:0] bs[], input logic cs[]);
      exp_t e;
      int lat, busy_n;
      for (int i = 0; i < ops.size(); i++) begin
         drive_op(ops[i], as[i], bs[i], cs[i]);
         wait_done(1, lat, busy_n);
         e = sb.pop_front();
         checks++;
         if (obs_w !== {e.r, e.hi, e.z, e.c, e.v, e.lf})
            $display("FAIL %s[%0d] op=%0d: got r=%h hi=%h z=%b c=%b v=%b lf=%b want r=%h hi=%h z=%b c=%b v=%b lf=%b",
                     name, i, ops[i], bus.result, bus.result_hi, bus.zero_out, bus.carry_out,
                     bus.overflow_out, bus.load_flags, e.r, e.hi, e.z, e.c, e.v, e.lf);
         else passed++;
         checks++;
         if (lat !== e.lat || busy_n !== e.lat - 1 || bus.busy !== 1'b0)
            $display("FAIL %s[%0d]_latency: got lat=%0d busy=%0d want lat=%0d busy=%0d",
                     name, i, lat, busy_n, e.lat, e.lat - 1);
         else passed++;
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.load_flags !== 1'b0 || bus.result !== e.r)
            $display("FAIL %s[%0d]_pulse: got done=%b lf=%b r=%h want done=0 lf=0 r=%h",
                     name, i, bus.done, bus.load_flags, bus.result, e.r);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_mul();
      drive_op(4'd11, 8'h10, 8'h10, 1'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({obs_w, bus.busy, bus.done} !== 22'd0) $display("FAIL reset_mid_mul: got %h want 0", {obs_w, bus.busy, bus.done});
      else passed++;
      model_reset();
      repeat (12) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0) $display("FAIL reset_no_done: got done=%b want 0", bus.done);
         else passed++;
      end
      reset_n = 1'b1;
      test_table("post_reset_add", '{4'd0}, '{8'h01}, '{8'h01}, '{1'b0});
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int lat, busy_n;
      drive_op(4'd8, 8'h81, 8'h02, 1'b0);
      wait_done(1, lat, busy_n);
      e = sb.pop_front();
      checks++;
      if (obs_w !== {e.r, e.hi, e.z, e.c, e.v, e.lf} || lat !== e.lat)
         $display("FAIL b2b_shl: got r=%h c=%b lat=%0d want r=%h c=%b lat=%0d", bus.result, bus.carry_out, lat, e.r, e.c, e.lat);
      else passed++;
      bus.start = 1'b1; bus.op = 4'd6; bus.a = 8'hAA; bus.b = 8'hAA; bus.carry_in = 1'b0;
      push_expect(4'd6, 8'hAA, 8'hAA, 1'b0);
      @(negedge clk);
      bus.start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (bus.done !== 1'b1 || obs_w !== {e.r, e.hi, e.z, e.c, e.v, e.lf})
         $display("FAIL b2b_xor: got done=%b r=%h z=%b want done=1 r=%h z=%b", bus.done, bus.result, bus.zero_out, e.r, e.z);
      else passed++;
      // ADD launched mid-MUL must be dropped: no extra done, MUL result intact.
      drive_op(4'd11, 8'h0D, 8'h0B, 1'b0);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(3, lat, busy_n);
      e = sb.pop_front();
      checks++;
      if (obs_w !== {e.r, e.hi, e.z, e.c, e.v, e.lf} || lat !== e.lat)
         $display("FAIL mul_ignore_add: got r=%h hi=%h lat=%0d want r=%h hi=%h lat=%0d", bus.result, bus.result_hi, lat, e.r, e.hi, e.lat);
      else passed++;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.result !== e.r) $display("FAIL mul_ignore_extra: got done=%b r=%h want done=0 r=%h", bus.done, bus.result, e.r);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_mul();
      test_table("arith", '{4'd0, 4'd0, 4'd2, 4'd1, 4'd3, 4'd12, 4'd2},
                          '{8'h7F, 8'hFF, 8'h80, 8'hFE, 8'h00, 8'h05, 8'h10},
                          '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h05, 8'h20},
                          '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      test_table("logic", '{4'd4, 4'd5, 4'd6, 4'd7},
                          '{8'hF0, 8'h0F, 8'h55, 8'hFF},
                          '{8'h3C, 8'h30, 8'hAA, 8'h00},
                          '{1'b0, 1'b0, 1'b0, 1'b0});
      test_table("shift", '{4'd8, 4'd10, 4'd9, 4'd9, 4'd10},
                          '{8'h81, 8'h81, 8'h5A, 8'h81, 8'h96},
                          '{8'h03, 8'h01, 8'h00, 8'h07, 8'h0F},
                          '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
      test_table("mul", '{4'd11, 4'd11, 4'd11},
                        '{8'hFF, 8'h00, 8'h0F},
                        '{8'hFF, 8'h37, 8'h11},
                        '{1'b0, 1'b0, 1'b0});
      test_back_to_back();
      test_table("reserved", '{4'd14, 4'd15}, '{8'h12, 8'h00}, '{8'h34, 8'h00}, '{1'b1, 1'b0});
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
